seq_checker: RTL and testbench

- Downstream consumer of the 3-bit cyclic sequence generator's output (`man_out`).
- Checks every accepted sample against the generator's fixed 8-state successor order and acquires lock.
- Flags and counts sequence errors and counts completed periods.
- Sits between the generator and the status/display logic; registered outputs only.

---
 rtl/seq_checker.sv | 202 ++++++++++++++++++++
 tb/tb_seq_checker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seq_checker.sv
// -----------------------------------------------------------------------------
// seq_checker
//
// Consumes the 3-bit cyclic sequence produced by the sequence generator and
// checks each accepted sample against the generator's fixed 8-state successor
// order (0->3->2->5->1->6->4->7->0). It acquires lock after LOCK_LEN
// consecutive correct transitions. It drops lock after UNLOCK_LEN consecutive
// wrong transitions. While locked it flags and counts errors and counts
// completed periods (7->0 transitions). All outputs are registered.
//
// Build option:
//   SEQ_CHK_RESYNC_EN  When defined, a mismatch while LOCKED re-aligns the
//                      prediction to the received value (resync). When not
//                      defined, the prediction keeps following the ideal
//                      sequence (flywheel).
//
// Parameters:
//   LOCK_LEN    consecutive correct transitions needed to lock (1..15)
//   UNLOCK_LEN  consecutive wrong transitions that drop lock (1..15)
//   CNT_W       width of err_cnt and wrap_cnt
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active-high
//   in_valid  in   din carries a sample this cycle
//   din       in   3-bit sequence code from the generator
//   locked    out  checker is in LOCKED
//   err       out  one-cycle pulse per wrong transition while LOCKED
//   err_cnt   out  saturating count of err pulses
//   wrap_cnt  out  completed periods while LOCKED, wraps modulo 2^CNT_W
//   exp_out   out  value expected for the next sample, succ(prev)
// -----------------------------------------------------------------------------
module seq_checker #(
    parameter int LOCK_LEN   = 4,
    parameter int UNLOCK_LEN = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [2:0]       din,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic [2:0]       exp_out
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Generator successor order, period 8.
    function automatic logic [2:0] succ(input logic [2:0] v);
        logic [2:0] r;
        case (v)
            3'd0:    r = 3'd3;
            3'd3:    r = 3'd2;
            3'd2:    r = 3'd5;
            3'd5:    r = 3'd1;
            3'd1:    r = 3'd6;
            3'd6:    r = 3'd4;
            3'd4:    r = 3'd7;
            3'd7:    r = 3'd0;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    state_t           state_q,    state_d;
    logic [2:0]       prev_q,     prev_d;
    logic             prev_ok_q,  prev_ok_d;
    logic [3:0]       run_cnt_q,  run_cnt_d;
    logic [3:0]       miss_cnt_q, miss_cnt_d;
    logic             err_q,      err_d;
    logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;
    logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic             locked_q,   locked_d;
    logic [2:0]       exp_q,      exp_d;

    logic             match;
    logic [4:0]       run_inc;
    logic [4:0]       miss_inc;

    // Counters are compared one bit wider so a terminal count of 15 still
    // fits without overflow in the comparison.
    assign match    = (din == succ(prev_q));
    assign run_inc  = {1'b0, run_cnt_q} + 5'd1;
    assign miss_inc = {1'b0, miss_cnt_q} + 5'd1;

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        prev_ok_d  = prev_ok_q;
        run_cnt_d  = run_cnt_q;
        miss_cnt_d = miss_cnt_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;

        if (in_valid) begin
            if (!prev_ok_q) begin
                // First sample after reset only seeds the history.
                prev_d    = din;
                prev_ok_d = 1'b1;
            end else begin
                case (state_q)
                    HUNT: begin
                        prev_d = din;
                        if (match) begin
                            if (run_inc == 5'(LOCK_LEN)) begin
                                state_d    = LOCKED;
                                run_cnt_d  = 4'd0;
                                miss_cnt_d = 4'd0;
                            end else begin
                                run_cnt_d = run_inc[3:0];
                            end
                        end else begin
                            run_cnt_d = 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            miss_cnt_d = 4'd0;
                            prev_d     = din;
                            if (din == 3'd0) begin
                                wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
                            end
                        end else begin
                            err_d     = 1'b1;
                            err_cnt_d = sat_inc(err_cnt_q);
`ifdef SEQ_CHK_RESYNC_EN
                            prev_d    = din;
`else
                            prev_d    = succ(prev_q);
`endif
                            if (miss_inc == 5'(UNLOCK_LEN)) begin
                                state_d    = HUNT;
                                miss_cnt_d = 4'd0;
                                run_cnt_d  = 4'd0;
                            end else begin
                                miss_cnt_d = miss_inc[3:0];
                            end
                        end
                    end
                    default: begin
                        state_d = HUNT;
                    end
                endcase
            end
        end

        locked_d = (state_d == LOCKED);
        exp_d    = succ(prev_d);
    end

    // Register boundary: everything the outputs show comes from here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            prev_q     <= 3'd0;
            prev_ok_q  <= 1'b0;
            run_cnt_q  <= 4'd0;
            miss_cnt_q <= 4'd0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
            locked_q   <= 1'b0;
            exp_q      <= 3'd3;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            prev_ok_q  <= prev_ok_d;
            run_cnt_q  <= run_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
            locked_q   <= locked_d;
            exp_q      <= exp_d;
        end
    end

    assign locked   = locked_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;
    assign wrap_cnt = wrap_cnt_q;
    assign exp_out  = exp_q;

endmodule

// File: tb/tb_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_seq_checker
//
// Directed bench for seq_checker. dut drives the default configuration
// (CNT_W=8). sat_dut uses CNT_W=2 and receives the same inputs; only its
// err_cnt is checked, in the saturation section. Expected values are
// hand-computed; where they depend on SEQ_CHK_RESYNC_EN the bench selects
// them with the same macro.
// -----------------------------------------------------------------------------
module tb_seq_checker;

`ifdef SEQ_CHK_RESYNC_EN
    localparam int RESYNC = 1;
`else
    localparam int RESYNC = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] din;

    logic       locked,   locked2;
    logic       err,      err2;
    logic [7:0] err_cnt,  wrap_cnt;
    logic [1:0] err_cnt2, wrap_cnt2;
    logic [2:0] exp_out,  exp_out2;

    int n_cmp = 0;
    int n_mis = 0;

    logic [2:0] seq [8] = '{3'd0, 3'd3, 3'd2, 3'd5, 3'd1, 3'd6, 3'd4, 3'd7};

    always #5 clk = ~clk;

    seq_checker #(.LOCK_LEN(4), .UNLOCK_LEN(3), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .din      (din),
        .locked   (locked),
        .err      (err),
        .err_cnt  (err_cnt),
        .wrap_cnt (wrap_cnt),
        .exp_out  (exp_out)
    );

    seq_checker #(.LOCK_LEN(4), .UNLOCK_LEN(3), .CNT_W(2)) sat_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .din      (din),
        .locked   (locked2),
        .err      (err2),
        .err_cnt  (err_cnt2),
        .wrap_cnt (wrap_cnt2),
        .exp_out  (exp_out2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample #1 after the edge.
    task automatic step(input logic v, input logic [2:0] d);
        in_valid = v;
        din      = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pos;
        logic [2:0] w;

        rst      = 1'b1;
        in_valid = 1'b0;
        din      = 3'd0;
        step(1'b0, 3'd0);
        step(1'b0, 3'd0);
        rst = 1'b0;

        // Reset state
        check("rst_locked",   locked,   0);
        check("rst_err",      err,      0);
        check("rst_err_cnt",  err_cnt,  0);
        check("rst_wrap_cnt", wrap_cnt, 0);
        check("rst_exp_out",  exp_out,  3);

        // Lock acquisition: 0,3,2,5,1
        step(1'b1, 3'd0); check("lk_s1_locked", locked, 0); check("lk_s1_exp", exp_out, 3);
        step(1'b1, 3'd3); check("lk_s2_locked", locked, 0); check("lk_s2_exp", exp_out, 2);
        step(1'b1, 3'd2); check("lk_s3_locked", locked, 0);
        step(1'b1, 3'd5); check("lk_s4_locked", locked, 0); check("lk_s4_err", err, 0);
        step(1'b1, 3'd1); check("lk_s5_locked", locked, 1); check("lk_s5_err", err, 0);
        check("lk_s5_exp", exp_out, 6);

        // Period count: 16 more correct samples starting at 6
        for (int i = 0; i < 16; i++) begin
            step(1'b1, seq[(5 + i) % 8]);
            check("per_err", err, 0);
        end
        check("per_wrap_cnt", wrap_cnt, 2);
        check("per_err_cnt",  err_cnt,  0);
        check("per_locked",   locked,   1);
        check("per_exp",      exp_out,  6);

        // Single corrupted sample: advance to where 5 is expected, send 4
        for (int i = 0; i < 6; i++) step(1'b1, seq[(5 + i) % 8]);
        check("cor_wrap_cnt", wrap_cnt, 3);
        check("cor_exp5",     exp_out,  5);
        step(1'b1, 3'd4);
        check("cor_err",      err,      1);
        check("cor_err_cnt1", err_cnt,  1);
        check("cor_locked1",  locked,   1);
        step(1'b1, 3'd1);
        check("cor_err_next", err,      RESYNC);
        step(1'b1, 3'd6);
        check("cor_err_last", err,      0);
        check("cor_err_cnt",  err_cnt,  1 + RESYNC);
        check("cor_locked",   locked,   1);

        // Loss of lock: expected 4, send 6 three times
        step(1'b1, 3'd6); check("los1_err", err, 1); check("los1_locked", locked, 1);
        step(1'b1, 3'd6); check("los2_err", err, 1); check("los2_locked", locked, 1);
        step(1'b1, 3'd6); check("los3_err", err, 1); check("los3_locked", locked, 0);
        check("los_err_cnt", err_cnt, 4 + RESYNC);
        step(1'b1, 3'd6); check("los4_err", err, 0); check("los4_locked", locked, 0);
        check("los4_err_cnt", err_cnt, 4 + RESYNC);

        // Valid gaps: pattern 1,0,0 with garbage on din while invalid
        rst = 1'b1;
        step(1'b0, 3'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seq[i]);
            check("gap_locked_v", locked, (i == 4) ? 1 : 0);
            step(1'b0, 3'd7);
            check("gap_err_i1", err, 0);
            step(1'b0, 3'd6);
            check("gap_locked_i", locked, (i == 4) ? 1 : 0);
        end
        check("gap_exp", exp_out, 6);
        for (int i = 0; i < 4; i++) step(1'b1, seq[(5 + i) % 8]);
        check("gap_wrap_cnt", wrap_cnt, 1);
        check("gap_err_cnt",  err_cnt,  0);

        // Reset while locked; rst overrides in_valid
        rst = 1'b1;
        step(1'b1, 3'd3);
        rst = 1'b0;
        check("rl_locked",   locked,   0);
        check("rl_err",      err,      0);
        check("rl_err_cnt",  err_cnt,  0);
        check("rl_wrap_cnt", wrap_cnt, 0);
        check("rl_exp",      exp_out,  3);
        step(1'b1, 3'd5);
        check("rl_first_exp", exp_out, 1);
        check("rl_first_err", err,     0);

        // Saturation: lock, then 5 isolated corrupted samples
        rst = 1'b1;
        step(1'b0, 3'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, seq[i]);
        check("sat_locked0", locked2, 1);
        pos = 5;
        for (int e = 0; e < 5; e++) begin
            w = seq[pos % 8] + 3'd1;
            step(1'b1, w);
            pos++;
            for (int k = 0; k < 3; k++) begin
                step(1'b1, seq[pos % 8]);
                pos++;
            end
            check("sat_err_cnt2", err_cnt2,
                  ((e + 1) * (1 + RESYNC) > 3) ? 3 : (e + 1) * (1 + RESYNC));
            check("sat_locked", locked2, 1);
        end
        check("sat_err_cnt_main", err_cnt, 5 * (1 + RESYNC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
